alu_ctrl_md: RTL and testbench
==============================

ALU_CTRL_MD -- requirements
Module: alu_ctrl_md

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning operand and result width (power of two, 8..64).
REQ-002 SHALL have ports: clk  in  1  rising-edge clock.
REQ-003 SHALL have ports: rst  in  1  reset, asynchronous and active-high.
REQ-004 SHALL have ports: in_valid  in  1  request present; in_ready  out  1  request accepted when both high.
REQ-005 SHALL have ports: alu_op  in  2; funct7  in  7; funct3  in  3  instruction decode fields.
REQ-006 SHALL have ports: src_a, src_b  in  XLEN  operands, used only by multiply/divide ops.
REQ-007 SHALL have ports: flush  in  1  synchronous abort of the in-flight request.
REQ-008 SHALL have ports: out_valid  out  1; out_ready  in  1  result handshake.
REQ-009 SHALL have ports: alu_func  out  4  OP_* code; use_md  out  1  md_result selected; md_result  out  XLEN; illegal  out  1  alu_func is OP_EEE.

Function
REQ-010 SHALL implement FSM states IDLE, MUL, DIV, DONE; in_ready = (state==IDLE).
REQ-011 SHALL register all outputs when a request is accepted, taken in IDLE.
REQ-012 SHALL decode alu_op 00 -> OP_ADD.
REQ-013 SHALL decode alu_op 01 by funct3: 000/001 -> OP_SUB; 100/101 -> OP_SLT; 110/111 -> OP_SLTU; 010/011 -> OP_EEE.
REQ-014 SHALL decode alu_op 10 with funct7 0x00/0x20 per the R-type table (add, sub, xor, or, and, sll, srl, sra, slt, sltu); any other {funct7[5],funct3} -> OP_EEE.
REQ-015 SHALL treat alu_op 10 with funct7==0x01 as M-extension: funct3 000 mul, 001 mulh, 010 mulhsu, 011 mulhu, 100 div, 101 divu, 110 rem, 111 remu.
REQ-016 SHALL decode alu_op 11 (I-type): 000 ADD, 100 XOR, 110 OR, 111 AND, 010 SLT, 011 SLTU, 001 SLL (funct7[5]=1 -> OP_EEE), 101 SRL/SRA by funct7[5].
REQ-017 SHALL treat any funct7 other than 0x00, 0x20 or 0x01 under alu_op 10 as OP_EEE.
REQ-018 SHALL complete non-M ops IDLE -> DONE: out_valid one cycle after accept, use_md=0, md_result=0.
REQ-019 SHALL run multiply as a radix-2 iterative engine, XLEN iterations in MUL; out_valid XLEN+1 cycles after accept; use_md=1; alu_func=OP_ADD.
REQ-020 SHALL run division as a restoring iterative engine, XLEN iterations in DIV; out_valid XLEN+1 cycles after accept; signed ops correct signs afterwards.
REQ-021 SHALL handle divisor zero in 1 cycle: quotient all ones, remainder = src_a.
REQ-022 SHALL handle signed overflow (most-negative / -1) in 1 cycle: quotient = src_a, remainder 0.
REQ-023 SHALL hold out_valid and all outputs stable in DONE until out_ready; DONE -> IDLE on out_ready.
REQ-024 SHALL on flush in any state return to IDLE next cycle, with no out_valid for the aborted request; flush has priority over in_valid and out_ready.
REQ-025 SHALL set illegal=1 exactly when alu_func=OP_EEE and use_md=0.

Reset
REQ-026 SHALL on rst, regardless of clk and mid-operation: state IDLE, in_ready=1, out_valid=0, alu_func=4'b0000, use_md=0, md_result=0, illegal=0, engine registers cleared.
REQ-027 SHALL accept a request on the first rising edge after rst deasserts.

Configuration
REQ-028 SHALL, with ALU_CTRL_DIV_EN defined, include the divider and DIV state per REQ-020..022.
REQ-029 SHALL, without ALU_CTRL_DIV_EN, omit the divider: funct7 0x01 with funct3 1xx -> alu_func=OP_EEE, illegal=1, use_md=0, 1-cycle completion; multiply unaffected.

Verification
REQ-030 SHALL cover: alu_op=11, funct3=101, funct7=0x20 -> out_valid next cycle, alu_func=OP_SRA, illegal=0; alu_op=01, funct3=010 -> OP_EEE, illegal=1.
REQ-031 SHALL cover: XLEN=32, mulh 0xFFFFFFFF*0x00000002 -> md_result 0xFFFFFFFF at cycle 33; mulhu -> 0x00000001; mul -> 0xFFFFFFFE.
REQ-032 SHALL cover: div 7 / 0xFFFFFFFE -> 0xFFFFFFFD; rem -> 0x00000001; divu 0xFFFFFFFF / 16 -> 0x0FFFFFFF, all at cycle 33.
REQ-033 SHALL cover: divu by 0 -> 0xFFFFFFFF at cycle 1; remu 5 by 0 -> 5; div 0x80000000 / 0xFFFFFFFF -> 0x80000000 at cycle 1.
REQ-034 SHALL cover: out_ready low 5 cycles in DONE -> outputs held, in_ready=0; flush at cycle 10 of mul -> no out_valid, in_ready=1 next cycle.
REQ-035 SHALL cover: rst pulse mid-division -> all outputs at reset values immediately; a new add request completes normally afterwards.

Source files
------------

// File: rtl/alu_ctrl_md.sv
// ALU control decoder with an iterative radix-2 multiplier and an optional restoring divider.
// Define ALU_CTRL_DIV_EN to include the divider (DIV state); without it, divide ops decode as OP_EEE.
module alu_ctrl_md #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      alu_op,
    input  logic [6:0]      funct7,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] src_a,
    input  logic [XLEN-1:0] src_b,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [3:0]      alu_func,
    output logic            use_md,
    output logic [XLEN-1:0] md_result,
    output logic            illegal
);
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_XOR = 4'd2, OP_OR = 4'd3,
                           OP_AND = 4'd4, OP_SLL = 4'd5, OP_SRL = 4'd6, OP_SRA = 4'd7,
                           OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_EEE = 4'd15;
    localparam int CW = $clog2(XLEN) + 1;

    typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

    state_t          state_q, state_d;
    logic            out_valid_q, out_valid_d, use_md_q, use_md_d, illegal_q, illegal_d;
    logic [3:0]      alu_func_q, alu_func_d;
    logic [XLEN-1:0] md_result_q, md_result_d;
    // Engine registers are shared: {acc,lo} is the product for MUL, {remainder,quotient} for DIV.
    logic [XLEN-1:0] acc_q, acc_d, lo_q, lo_d, opnd_q, opnd_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            neg_q, neg_d, hi_sel_q, hi_sel_d;

    logic [3:0]        dec_func;
    logic              dec_mul, dec_div;
    logic              a_neg, b_neg;
    logic [XLEN-1:0]   a_mag, b_mag;
    logic [XLEN:0]     mul_add;
    logic [2*XLEN-1:0] mul_next, mul_fin;

    always_comb begin
        dec_func = OP_EEE;
        dec_mul  = 1'b0;
        dec_div  = 1'b0;
        case (alu_op)
            2'b00: dec_func = OP_ADD;
            2'b01: begin
                case (funct3)
                    3'b000, 3'b001: dec_func = OP_SUB;
                    3'b100, 3'b101: dec_func = OP_SLT;
                    3'b110, 3'b111: dec_func = OP_SLTU;
                    default:        dec_func = OP_EEE;
                endcase
            end
            2'b10: begin
                if (funct7 == 7'h01) begin
                    dec_func = OP_ADD;
                    if (!funct3[2]) begin
                        dec_mul = 1'b1;
                    end else begin
`ifdef ALU_CTRL_DIV_EN
                        dec_div = 1'b1;
`else
                        dec_func = OP_EEE;
`endif
                    end
                end else if (funct7 == 7'h00 || funct7 == 7'h20) begin
                    case ({funct7[5], funct3})
                        4'b0000: dec_func = OP_ADD;
                        4'b1000: dec_func = OP_SUB;
                        4'b0001: dec_func = OP_SLL;
                        4'b0010: dec_func = OP_SLT;
                        4'b0011: dec_func = OP_SLTU;
                        4'b0100: dec_func = OP_XOR;
                        4'b0101: dec_func = OP_SRL;
                        4'b1101: dec_func = OP_SRA;
                        4'b0110: dec_func = OP_OR;
                        4'b0111: dec_func = OP_AND;
                        default: dec_func = OP_EEE;
                    endcase
                end
            end
            default: begin
                case (funct3)
                    3'b000:  dec_func = OP_ADD;
                    3'b100:  dec_func = OP_XOR;
                    3'b110:  dec_func = OP_OR;
                    3'b111:  dec_func = OP_AND;
                    3'b010:  dec_func = OP_SLT;
                    3'b011:  dec_func = OP_SLTU;
                    3'b001:  dec_func = funct7[5] ? OP_EEE : OP_SLL;
                    default: dec_func = funct7[5] ? OP_SRA : OP_SRL;
                endcase
            end
        endcase
    end

    // Signedness of each operand: mulh/div/rem both signed, mulhsu only src_a.
    assign a_neg = src_a[XLEN-1] & ((funct3 == 3'b001) | (funct3 == 3'b010) | (funct3[2] & ~funct3[0]));
    assign b_neg = src_b[XLEN-1] & ((funct3 == 3'b001) | (funct3[2] & ~funct3[0]));
    assign a_mag = a_neg ? -src_a : src_a;
    assign b_mag = b_neg ? -src_b : src_b;

    assign mul_add  = {1'b0, acc_q} + (lo_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_add, lo_q[XLEN-1:1]};
    assign mul_fin  = neg_q ? -mul_next : mul_next;

`ifdef ALU_CTRL_DIV_EN
    logic [XLEN:0]   div_shift, div_diff;
    logic [XLEN-1:0] rem_next, quo_next, div_val;
    logic            div_ovf;
    assign div_shift = {acc_q, lo_q[XLEN-1]};
    assign div_diff  = div_shift - {1'b0, opnd_q};
    assign rem_next  = div_diff[XLEN] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
    assign quo_next  = {lo_q[XLEN-2:0], ~div_diff[XLEN]};
    assign div_val   = hi_sel_q ? rem_next : quo_next;
    assign div_ovf   = ~funct3[0] && (src_a == {1'b1, {(XLEN-1){1'b0}}}) && (src_b == {XLEN{1'b1}});
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q;
        alu_func_d  = alu_func_q;
        use_md_d    = use_md_q;
        md_result_d = md_result_q;
        illegal_d   = illegal_q;
        acc_d       = acc_q;
        lo_d        = lo_q;
        opnd_d      = opnd_q;
        cnt_d       = cnt_q;
        neg_d       = neg_q;
        hi_sel_d    = hi_sel_q;
        if (flush) begin
            state_d     = IDLE;
            out_valid_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: if (in_valid) begin
                    alu_func_d  = dec_func;
                    use_md_d    = dec_mul | dec_div;
                    illegal_d   = (dec_func == OP_EEE) && !(dec_mul | dec_div);
                    md_result_d = '0;
                    cnt_d       = '0;
                    state_d     = DONE;
                    out_valid_d = 1'b1;
                    if (dec_mul) begin
                        acc_d       = '0;
                        lo_d        = b_mag;
                        opnd_d      = a_mag;
                        neg_d       = a_neg ^ b_neg;
                        hi_sel_d    = (funct3[1:0] != 2'b00);
                        state_d     = MUL;
                        out_valid_d = 1'b0;
                    end
`ifdef ALU_CTRL_DIV_EN
                    if (dec_div) begin
                        if (src_b == '0) begin
                            md_result_d = funct3[1] ? src_a : {XLEN{1'b1}};
                        end else if (div_ovf) begin
                            md_result_d = funct3[1] ? '0 : src_a;
                        end else begin
                            acc_d       = '0;
                            lo_d        = a_mag;
                            opnd_d      = b_mag;
                            neg_d       = funct3[1] ? a_neg : (a_neg ^ b_neg);
                            hi_sel_d    = funct3[1];
                            state_d     = DIV;
                            out_valid_d = 1'b0;
                        end
                    end
`endif
                end
                MUL: begin
                    acc_d = mul_next[2*XLEN-1:XLEN];
                    lo_d  = mul_next[XLEN-1:0];
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        md_result_d = hi_sel_q ? mul_fin[2*XLEN-1:XLEN] : mul_fin[XLEN-1:0];
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
`ifdef ALU_CTRL_DIV_EN
                DIV: begin
                    acc_d = rem_next;
                    lo_d  = quo_next;
                    cnt_d = cnt_q + CW'(1);
                    if (cnt_q == CW'(XLEN-1)) begin
                        md_result_d = neg_q ? -div_val : div_val;
                        state_d     = DONE;
                        out_valid_d = 1'b1;
                    end
                end
`endif
                DONE: if (out_ready) begin
                    state_d     = IDLE;
                    out_valid_d = 1'b0;
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            alu_func_q  <= 4'b0000;
            use_md_q    <= 1'b0;
            md_result_q <= '0;
            illegal_q   <= 1'b0;
            acc_q       <= '0;
            lo_q        <= '0;
            opnd_q      <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            hi_sel_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            alu_func_q  <= alu_func_d;
            use_md_q    <= use_md_d;
            md_result_q <= md_result_d;
            illegal_q   <= illegal_d;
            acc_q       <= acc_d;
            lo_q        <= lo_d;
            opnd_q      <= opnd_d;
            cnt_q       <= cnt_d;
            neg_q       <= neg_d;
            hi_sel_q    <= hi_sel_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = out_valid_q;
    assign alu_func  = alu_func_q;
    assign use_md    = use_md_q;
    assign md_result = md_result_q;
    assign illegal   = illegal_q;
endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed testbench for alu_ctrl_md (XLEN=32) with a scoreboard queue of expected results.
module tb_alu_ctrl_md;
    localparam logic [3:0] OP_ADD = 4'd0, OP_SUB = 4'd1, OP_AND = 4'd4, OP_SLL = 4'd5,
                           OP_SRA = 4'd7, OP_SLT = 4'd8, OP_SLTU = 4'd9, OP_EEE = 4'd15;

    typedef struct {
        logic [3:0]  func;
        logic        md;
        logic [31:0] res;
        logic        ill;
        int          lat;
    } exp_t;

    logic        clk = 1'b0, rst = 1'b1;
    logic        in_valid = 1'b0, in_ready, flush = 1'b0, out_valid, out_ready = 1'b0;
    logic [1:0]  alu_op = '0;
    logic [6:0]  funct7 = '0;
    logic [2:0]  funct3 = '0;
    logic [31:0] src_a = '0, src_b = '0, md_result;
    logic [3:0]  alu_func;
    logic        use_md, illegal;

    exp_t sb_q[$];
    int   tests = 0, fails = 0;

    always #5 clk = ~clk;

    alu_ctrl_md #(.XLEN(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .funct7(funct7), .funct3(funct3), .src_a(src_a), .src_b(src_b),
        .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
        .alu_func(alu_func), .use_md(use_md), .md_result(md_result), .illegal(illegal)
    );

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t mk(input logic [3:0] f, input logic md, input logic [31:0] r,
                                input logic ill, input int lat);
        exp_t e;
        e.func = f; e.md = md; e.res = r; e.ill = ill; e.lat = lat;
        return e;
    endfunction

    function automatic logic [31:0] mul_model(input logic [2:0] f3, input logic [31:0] a,
                                              input logic [31:0] b);
        logic [63:0] ea, eb, p;
        ea = (f3 == 3'b001 || f3 == 3'b010) ? {{32{a[31]}}, a} : {32'b0, a};
        eb = (f3 == 3'b001) ? {{32{b[31]}}, b} : {32'b0, b};
        p  = ea * eb;
        return (f3 == 3'b000) ? p[31:0] : p[63:32];
    endfunction

    // Drive one request, wait for its result, compare against the scoreboard, then hand it off.
    task automatic issue(input string name, input logic [1:0] op, input logic [6:0] f7,
                         input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                         input exp_t e, input int hold);
        exp_t g;
        int   cyc;
        check({name, ":in_ready"}, 64'(in_ready), 64'(1));
        alu_op = op; funct7 = f7; funct3 = f3; src_a = a; src_b = b; in_valid = 1'b1;
        sb_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 1;
        while (!out_valid && cyc < 100) begin
            @(posedge clk); #1;
            cyc++;
        end
        g = sb_q.pop_front();
        check({name, ":latency"}, 64'(cyc), 64'(g.lat));
        check({name, ":alu_func"}, 64'(alu_func), 64'(g.func));
        check({name, ":use_md"}, 64'(use_md), 64'(g.md));
        check({name, ":md_result"}, 64'(md_result), 64'(g.res));
        check({name, ":illegal"}, 64'(illegal), 64'(g.ill));
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check({name, ":hold_valid"}, 64'(out_valid), 64'(1));
            check({name, ":hold_in_ready"}, 64'(in_ready), 64'(0));
            check({name, ":hold_result"}, 64'(md_result), 64'(g.res));
            check({name, ":hold_func"}, 64'(alu_func), 64'(g.func));
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check({name, ":released"}, 64'(out_valid), 64'(0));
        $display("[TB] %s func=%0d md=%0b res=%08h ill=%0b lat=%0d", name, alu_func, use_md,
                 md_result, illegal, cyc);
    endtask

    task automatic check_reset_outputs(input string name);
        check({name, ":in_ready"}, 64'(in_ready), 64'(1));
        check({name, ":out_valid"}, 64'(out_valid), 64'(0));
        check({name, ":alu_func"}, 64'(alu_func), 64'(0));
        check({name, ":use_md"}, 64'(use_md), 64'(0));
        check({name, ":md_result"}, 64'(md_result), 64'(0));
        check({name, ":illegal"}, 64'(illegal), 64'(0));
    endtask

    initial begin
        int seen;
        logic [31:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        check_reset_outputs("reset");
        rst = 1'b0;

        // Base decode, single-cycle completions
        issue("add", 2'b00, 7'h00, 3'b000, 32'h1, 32'h2, mk(OP_ADD, 0, 0, 0, 1), 0);
        issue("i_sra", 2'b11, 7'h20, 3'b101, 0, 0, mk(OP_SRA, 0, 0, 0, 1), 0);
        issue("br_eee", 2'b01, 7'h00, 3'b010, 0, 0, mk(OP_EEE, 0, 0, 1, 1), 0);
        issue("br_slt", 2'b01, 7'h00, 3'b101, 0, 0, mk(OP_SLT, 0, 0, 0, 1), 0);
        issue("r_sub", 2'b10, 7'h20, 3'b000, 0, 0, mk(OP_SUB, 0, 0, 0, 1), 0);
        issue("r_and", 2'b10, 7'h00, 3'b111, 0, 0, mk(OP_AND, 0, 0, 0, 1), 0);
        issue("r_eee20", 2'b10, 7'h20, 3'b001, 0, 0, mk(OP_EEE, 0, 0, 1, 1), 0);
        issue("r_f7bad", 2'b10, 7'h05, 3'b000, 0, 0, mk(OP_EEE, 0, 0, 1, 1), 0);
        issue("i_slleee", 2'b11, 7'h20, 3'b001, 0, 0, mk(OP_EEE, 0, 0, 1, 1), 0);
        issue("i_sll", 2'b11, 7'h00, 3'b001, 0, 0, mk(OP_SLL, 0, 0, 0, 1), 0);
        issue("i_sltu", 2'b11, 7'h00, 3'b011, 0, 0, mk(OP_SLTU, 0, 0, 0, 1), 0);

        // Multiply
        issue("mulh", 2'b10, 7'h01, 3'b001, 32'hFFFFFFFF, 32'h2, mk(OP_ADD, 1, 32'hFFFFFFFF, 0, 33), 0);
        issue("mulhu", 2'b10, 7'h01, 3'b011, 32'hFFFFFFFF, 32'h2, mk(OP_ADD, 1, 32'h00000001, 0, 33), 0);
        issue("mul", 2'b10, 7'h01, 3'b000, 32'hFFFFFFFF, 32'h2, mk(OP_ADD, 1, 32'hFFFFFFFE, 0, 33), 0);
        issue("mulhsu", 2'b10, 7'h01, 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, mk(OP_ADD, 1, 32'hFFFFFFFF, 0, 33), 0);
        for (int i = 0; i < 4; i++) begin
            ra = $urandom; rb = $urandom;
            issue($sformatf("mul_rand%0d", i), 2'b10, 7'h01, 3'(i), ra, rb,
                  mk(OP_ADD, 1, mul_model(3'(i), ra, rb), 0, 33), 0);
        end

`ifdef ALU_CTRL_DIV_EN
        issue("div", 2'b10, 7'h01, 3'b100, 32'd7, 32'hFFFFFFFE, mk(OP_ADD, 1, 32'hFFFFFFFD, 0, 33), 0);
        issue("rem", 2'b10, 7'h01, 3'b110, 32'd7, 32'hFFFFFFFE, mk(OP_ADD, 1, 32'h00000001, 0, 33), 0);
        issue("divu", 2'b10, 7'h01, 3'b101, 32'hFFFFFFFF, 32'd16, mk(OP_ADD, 1, 32'h0FFFFFFF, 0, 33), 0);
        issue("remu", 2'b10, 7'h01, 3'b111, 32'd100, 32'd7, mk(OP_ADD, 1, 32'd2, 0, 33), 0);
        issue("divu_z", 2'b10, 7'h01, 3'b101, 32'd9, 32'd0, mk(OP_ADD, 1, 32'hFFFFFFFF, 0, 1), 0);
        issue("remu_z", 2'b10, 7'h01, 3'b111, 32'd5, 32'd0, mk(OP_ADD, 1, 32'd5, 0, 1), 0);
        issue("div_ovf", 2'b10, 7'h01, 3'b100, 32'h80000000, 32'hFFFFFFFF, mk(OP_ADD, 1, 32'h80000000, 0, 1), 0);
        issue("rem_ovf", 2'b10, 7'h01, 3'b110, 32'h80000000, 32'hFFFFFFFF, mk(OP_ADD, 1, 32'h0, 0, 1), 0);
`else
        issue("divu_off", 2'b10, 7'h01, 3'b101, 32'd9, 32'd3, mk(OP_EEE, 0, 0, 1, 1), 0);
        issue("rem_off", 2'b10, 7'h01, 3'b110, 32'd9, 32'd3, mk(OP_EEE, 0, 0, 1, 1), 0);
`endif

        // Backpressure: result held for 5 cycles with out_ready low
        issue("mulhu_hold", 2'b10, 7'h01, 3'b011, 32'h80000000, 32'h6, mk(OP_ADD, 1, 32'h3, 0, 33), 5);

        // Flush at cycle 10 of a multiply
        alu_op = 2'b10; funct7 = 7'h01; funct3 = 3'b000; src_a = 32'd3; src_b = 32'd4; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) begin @(posedge clk); #1; end
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("flush:in_ready", 64'(in_ready), 64'(1));
        check("flush:out_valid", 64'(out_valid), 64'(0));
        seen = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        check("flush:no_valid", 64'(seen), 64'(0));
        $display("[TB] flush_mul aborted, later valids=%0d", seen);
        issue("add_after_flush", 2'b00, 7'h00, 3'b000, 0, 0, mk(OP_ADD, 0, 0, 0, 1), 0);

        // Asynchronous reset mid-operation, then a normal request
        issue("eee_before_rst", 2'b01, 7'h00, 3'b011, 0, 0, mk(OP_EEE, 0, 0, 1, 1), 0);
`ifdef ALU_CTRL_DIV_EN
        funct3 = 3'b101;
`else
        funct3 = 3'b001;
`endif
        alu_op = 2'b10; funct7 = 7'h01; src_a = 32'hFFFFFFFF; src_b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) begin @(posedge clk); #1; end
        check("midop:in_ready", 64'(in_ready), 64'(0));
        #2;
        rst = 1'b1;
        #1;
        check_reset_outputs("async_rst");
        @(posedge clk); #1;
        rst = 1'b0;
        $display("[TB] async reset mid-operation applied");
        issue("add_after_rst", 2'b00, 7'h00, 3'b000, 0, 0, mk(OP_ADD, 0, 0, 0, 1), 0);

        check("scoreboard_empty", 64'(sb_q.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
